demux_1to4: RTL
===============

Name: demux_1to4

Overview:
Registered 1-to-4 stream demultiplexer. It is the distribution-side counterpart of the team's 4-to-1 mux. A single valid/ready input stream is steered by a 2-bit select into one of four output channels (A/B/C/D). Each channel has its own one-entry output register and valid/ready handshake. It sits between a shared producer and four independent consumers.

Parameters:
- WIDTH, 4, data width of the input and of each output channel
- CNT_W, 8, width of the per-channel transfer counters (used only with the optional feature)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input data valid
- in_ready  output  1  demux can accept input this cycle
- in_data  input  WIDTH  input data
- sel  input  2  destination: 00=A, 01=B, 10=C, 11=D; sampled together with in_data
- A_valid, B_valid, C_valid, D_valid  output  1 each  channel holds valid data
- A_ready, B_ready, C_ready, D_ready  input  1 each  consumer accepts the channel data
- A, B, C, D  output  WIDTH each  channel data registers
- A_cnt, B_cnt, C_cnt, D_cnt  output  CNT_W each  accepted-transfer counters (optional feature)

Behaviour:
- Reset (rst_n=0, asynchronous): all x_valid=0, all data registers A..D=0, all counters=0. Reset takes effect immediately in any state; in-flight data is discarded. No input transfer is accepted while rst_n=0.
- Channel state machine, per channel, two states:
  - EMPTY (x_valid=0) -> FULL on load.
  - FULL -> EMPTY on drain with no load.
  - FULL -> FULL on load, or on no drain.
- Load of channel k: in_valid & in_ready & (sel==k) at a rising edge. Channel data <= in_data; x_valid <= 1.
- Drain of channel k: x_valid & x_ready at a rising edge.
- in_ready is combinational: in_ready = ~valid[sel] | ready[sel]. It depends only on the selected channel, so a stalled channel never blocks traffic to other channels.
- Latency: data accepted at edge N is visible on the channel output after edge N (1 cycle). Full throughput is 1 transfer per cycle per channel when the consumer holds ready=1.
- Simultaneous load and drain on the same channel: the load wins. x_valid stays 1 and the data updates to the new word.
- Unselected channels are unaffected by input activity. Their data registers hold while FULL.
- Data registers hold their value after drain. Consumers must qualify data with x_valid.
- sel and in_data are don't-care when in_valid=0.
- Handshake rule: once x_valid=1, the channel data is stable until drained. The input side must hold in_data/sel stable while in_valid=1 & in_ready=0.

Optional Feature:
- Macro: DEMUX_CNT_EN
- Defined: each channel keeps an unsigned CNT_W-bit counter of accepted loads. It increments on the same edge as the load and wraps from 2^CNT_W-1 to 0 without saturation. It resets to 0 under rst_n.
- Not defined: no counter logic is built and A_cnt..D_cnt are tied to 0. All other behaviour is identical.

Test Plan:
- Reset mid-traffic: load A with 4, then assert rst_n=0 between edges -> A_valid drops to 0 immediately, A=0, and counters=0 with no edge required.
- Sequential routing: with all ready=1, send data 4,5,8,15 with sel=00,01,10,11 on consecutive cycles -> A=4, B=5, C=8, D=15, each valid for exactly one cycle, one cycle after acceptance.
- Backpressure isolation: B_ready=0, send 5 to B and then 9 to B -> second word sees in_ready=0 and B holds 5. Then send 8 to C -> accepted and C=8 next cycle. Raise B_ready -> B drains 5, then 9 is accepted.
- Same-edge load/drain: C FULL with 8 and C_ready=1, send 12 to C -> C=12 next cycle with C_valid continuously 1.
- Counter wrap (DEMUX_CNT_EN, CNT_W=8): 256 loads to D -> D_cnt returns to 0. A_cnt, B_cnt and C_cnt stay unchanged. Build without the macro -> all counts read 0.

Source files
------------

// File: rtl/demux_1to4.sv
// Registered 1-to-4 valid/ready stream demultiplexer with one output register per channel.
// Optional per-channel accepted-load counters are built when DEMUX_CNT_EN is defined.
module demux_1to4 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       sel,
    output logic             A_valid,
    output logic             B_valid,
    output logic             C_valid,
    output logic             D_valid,
    input  logic             A_ready,
    input  logic             B_ready,
    input  logic             C_ready,
    input  logic             D_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [CNT_W-1:0] A_cnt,
    output logic [CNT_W-1:0] B_cnt,
    output logic [CNT_W-1:0] C_cnt,
    output logic [CNT_W-1:0] D_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t        r_state [4];
    logic [WIDTH-1:0] r_data  [4];

    logic [3:0] w_ready;
    logic [3:0] w_valid;
    logic [3:0] w_load;
    logic       w_accept;

    always_comb begin
        w_ready = {D_ready, C_ready, B_ready, A_ready};
        for (int k = 0; k < 4; k++) begin
            w_valid[k] = (r_state[k] == FULL);
        end
        // Only the addressed channel gates the input, so a stalled consumer blocks nobody else.
        in_ready = ~w_valid[sel] | w_ready[sel];
        w_accept = in_valid & in_ready;
        for (int k = 0; k < 4; k++) begin
            w_load[k] = w_accept & (sel == 2'(k));
        end
    end

    // NOTE: state is updated with non-blocking assignments so every channel sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= EMPTY;
                r_data[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                case (r_state[k])
                    EMPTY: begin
                        if (w_load[k]) begin
                            r_state[k] <= FULL;
                            r_data[k]  <= in_data;
                        end
                    end
                    FULL: begin
                        // A load on the draining edge wins: the channel stays FULL with the new word.
                        if (w_load[k]) begin
                            r_data[k] <= in_data;
                        end else if (w_ready[k]) begin
                            r_state[k] <= EMPTY;
                        end
                    end
                    default: r_state[k] <= EMPTY;
                endcase
            end
        end
    end

    assign A_valid = w_valid[0];
    assign B_valid = w_valid[1];
    assign C_valid = w_valid[2];
    assign D_valid = w_valid[3];
    assign A       = r_data[0];
    assign B       = r_data[1];
    assign C       = r_data[2];
    assign D       = r_data[3];

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt [4];

    // Counters wrap naturally at 2^CNT_W; no saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign A_cnt = r_cnt[0];
    assign B_cnt = r_cnt[1];
    assign C_cnt = r_cnt[2];
    assign D_cnt = r_cnt[3];
`else
    assign A_cnt = '0;
    assign B_cnt = '0;
    assign C_cnt = '0;
    assign D_cnt = '0;
`endif

endmodule
